// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - shared defaults and width helpers for the fractional baud generator
package baud_pkg;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_INC_W   = 12;
    localparam int DEF_OS_RATE = 16;

    localparam int OS_W = $clog2(DEF_OS_RATE);

    function automatic int phase_w(input int os_rate);
        return (os_rate > 1) ? $clog2(os_rate) : 1;
    endfunction

endpackage

// File: rtl/baud_os_div.sv
// rtl/baud_os_div.sv - oversample phase counter with bit-tick decode and mid-bit preset
module baud_os_div
    import baud_pkg::*;
#(
    parameter  int OS_RATE = DEF_OS_RATE,
    localparam int PW      = phase_w(OS_RATE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          clear,
    input  logic          preset,
    output logic [PW-1:0] os_phase,
    output logic          ce_bit
);

    localparam logic [PW-1:0] LAST = PW'(OS_RATE - 1);
    localparam logic [PW-1:0] HALF = PW'(OS_RATE / 2);

    // OS_RATE is a power of two, so the natural PW-bit rollover is the wrap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            os_phase <= '0;
            ce_bit   <= 1'b0;
        end else if (clear) begin
            os_phase <= '0;
            ce_bit   <= 1'b0;
        end else if (preset) begin
            os_phase <= HALF;
            ce_bit   <= 1'b0;
        end else begin
            ce_bit <= tick && (os_phase == LAST);
            if (tick) begin
                os_phase <= os_phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/baud_gen_os.sv
// rtl/baud_gen_os.sv - fractional baud generator top; BAUD_GEN_OS_RESYNC_EN enables resync
module baud_gen_os
    import baud_pkg::*;
#(
    parameter  int CNT_W   = DEF_CNT_W,
    parameter  int INC_W   = DEF_INC_W,
    parameter  int OS_RATE = DEF_OS_RATE,
    localparam int PW      = phase_w(OS_RATE)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [INC_W-1:0] cfg_freq,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             resync,
    output logic             ce_os,
    output logic             ce_bit,
    output logic [PW-1:0]    os_phase,
    output logic             cfg_pending
);

    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] limit_a;
    logic [CNT_W-1:0] limit_s;
    logic [INC_W-1:0] freq_a;
    logic [INC_W-1:0] freq_s;

    logic [CNT_W:0] acc_x;
    logic [CNT_W:0] limit_x;
    logic [CNT_W:0] freq_x;
    logic [CNT_W:0] sum;
    logic [CNT_W:0] diff;
    logic           wrap;
    logic           rs_eff;
    logic           tick;
    logic           apply;
    logic           unused_msb;

`ifdef BAUD_GEN_OS_RESYNC_EN
    assign rs_eff = resync;
`else
    logic unused_resync;
    assign unused_resync = resync;
    assign rs_eff        = 1'b0;
`endif

    assign acc_x      = {1'b0, acc};
    assign limit_x    = {1'b0, limit_a};
    assign freq_x     = {{(CNT_W + 1 - INC_W){1'b0}}, freq_a};
    assign sum        = acc_x + freq_x;
    assign diff       = acc_x - limit_x;
    assign wrap       = (acc_x >= limit_x);
    assign unused_msb = sum[CNT_W] ^ diff[CNT_W];

    assign tick  = enable && !rs_eff && wrap;
    assign apply = cfg_pending && (!enable || rs_eff || wrap);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            ce_os <= 1'b0;
        end else begin
            ce_os <= tick;
            if (!enable || rs_eff) begin
                acc <= '0;
            end else if (wrap) begin
                acc <= diff[CNT_W-1:0];
            end else begin
                acc <= sum[CNT_W-1:0];
            end
        end
    end

    // apply always moves the old shadow; a same-edge cfg_load refills it and keeps pending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            freq_a      <= '0;
            limit_a     <= '0;
            freq_s      <= '0;
            limit_s     <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (apply) begin
                freq_a  <= freq_s;
                limit_a <= limit_s;
            end
            if (cfg_load) begin
                freq_s      <= cfg_freq;
                limit_s     <= cfg_limit;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    baud_os_div #(
        .OS_RATE (OS_RATE)
    ) u_os_div (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .clear    (!enable),
        .preset   (enable && rs_eff),
        .os_phase (os_phase),
        .ce_bit   (ce_bit)
    );

endmodule

// File: tb/tb_baud_gen_os.sv
// tb/tb_baud_gen_os.sv - directed self-checking bench for baud_gen_os
module tb_baud_gen_os;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_load = 1'b0;
    logic [11:0] cfg_freq = '0;
    logic [15:0] cfg_limit = '0;
    logic        resync = 1'b0;
    logic        ce_os;
    logic        ce_bit;
    logic [3:0]  os_phase;
    logic        cfg_pending;

    int total = 0;
    int bad   = 0;

`ifdef BAUD_GEN_OS_RESYNC_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    baud_gen_os dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cfg_load    (cfg_load),
        .cfg_freq    (cfg_freq),
        .cfg_limit   (cfg_limit),
        .resync      (resync),
        .ce_os       (ce_os),
        .ce_bit      (ce_bit),
        .os_phase    (os_phase),
        .cfg_pending (cfg_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    // clocks until the next ce_os, bounded
    task automatic wait_os(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ce_os && n < 20000);
        if (!ce_os) chk("os_timeout", 0, 1);
    endtask

    // ce_os ticks until ce_bit, bounded
    task automatic wait_bit(output int ticks);
        int n;
        n = 0;
        ticks = 0;
        do begin
            @(negedge clock);
            n++;
            if (ce_os) ticks++;
        end while (!ce_bit && n < 20000);
        if (!ce_bit) chk("bit_timeout", 0, 1);
    endtask

    task automatic window(input int clks, output int nos, output int nbit, output int perr);
        logic [3:0] prev;
        nos = 0; nbit = 0; perr = 0;
        prev = os_phase;
        for (int i = 0; i < clks; i++) begin
            @(negedge clock);
            if (ce_bit && !ce_os) perr++;
            if (ce_os) begin
                nos++;
                if (os_phase != prev + 4'd1) perr++;
                prev = os_phase;
            end
            if (ce_bit) nbit++;
        end
    endtask

    task automatic load(input logic [11:0] f, input logic [15:0] l);
        cfg_freq  = f;
        cfg_limit = l;
        cfg_load  = 1'b1;
    endtask

    initial begin
        int n, nos, nbit, perr;

        #12;
        chk("rst_ce_os", ce_os, 0);
        chk("rst_ce_bit", ce_bit, 0);
        chk("rst_phase", os_phase, 0);
        chk("rst_pending", cfg_pending, 0);

        @(negedge clock);
        reset = 1'b1;
        load(1, 3);
        @(negedge clock);
        cfg_load = 1'b0;
        chk("load_pending", cfg_pending, 1);
        @(negedge clock);
        chk("idle_apply", cfg_pending, 0);

        // 1/3: tick every 4 clocks, bit every 16 ticks
        enable = 1'b1;
        wait_os(n);  chk("first_os_4", n, 4);
        wait_os(n);  chk("period_4", n, 4);
        wait_bit(n); chk("ticks_to_bit", n, 14);
        chk("phase_wrap", os_phase, 0);
        window(640, nos, nbit, perr);
        chk("win640_os", nos, 160);
        chk("win640_bit", nbit, 10);
        chk("win640_phase", perr, 0);

        // live reload to 1/7 applies on the next wrap
        wait_os(n);
        load(1, 7);
        @(negedge clock);
        cfg_load = 1'b0;
        chk("run_pending", cfg_pending, 1);
        wait_os(n);  chk("old_period_tail", n, 3);
        chk("applied_on_wrap", cfg_pending, 0);
        wait_os(n);  chk("new_period_8a", n, 8);
        wait_os(n);  chk("new_period_8b", n, 8);

        // 50 MHz / 115200
        load(576, 15049);
        @(negedge clock);
        cfg_load = 1'b0;
        wait_os(n);  chk("to_576", n, 7);
        repeat (20) @(negedge clock);
        window(15625, nos, nbit, perr);
        chk("win15625_os", nos, 576);
        chk("win15625_bit", nbit, 36);
        chk("win15625_phase", perr, 0);

        // disable mid-bit with a pending config
        load(1, 3);
        enable = 1'b0;
        @(negedge clock);
        cfg_load = 1'b0;
        chk("dis_ce_os", ce_os, 0);
        chk("dis_phase", os_phase, 0);
        chk("dis_pending_held", cfg_pending, 1);
        @(negedge clock);
        chk("dis_applied", cfg_pending, 0);
        enable = 1'b1;

        // resync right after the tick that lands on phase 5
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(ce_os && os_phase == 4'd5) && n < 200);
        chk("reach_phase5", os_phase, 5);
        resync = 1'b1;
        @(negedge clock);
        resync = 1'b0;
        chk("rs_ce_os", ce_os, 0);
        chk("rs_phase", os_phase, RS ? 8 : 5);
        wait_bit(n); chk("rs_ticks_to_bit", n, RS ? 8 : 11);

        // cfg_load coinciding with a disable-apply keeps the new shadow pending
        wait_os(n);
        load(1, 6);
        @(negedge clock);
        chk("pend_16", cfg_pending, 1);
        load(1, 9);
        enable = 1'b0;
        @(negedge clock);
        cfg_load = 1'b0;
        enable   = 1'b1;
        chk("collide_pending", cfg_pending, 1);
        chk("collide_phase", os_phase, 0);
        wait_os(n);  chk("reenable_first_7", n, 7);
        chk("collide_applied", cfg_pending, 0);
        wait_os(n);  chk("period_10", n, 10);

        // cfg_load on the wrap edge, then async reset while ce_os is high
        repeat (9) @(negedge clock);
        load(1, 3);
        @(negedge clock);
        cfg_load = 1'b0;
        chk("wrap_ce_os", ce_os, 1);
        chk("wrap_load_pending", cfg_pending, 1);
        enable = 1'b0;
        reset  = 1'b0;
        #1;
        chk("async_ce_os", ce_os, 0);
        chk("async_ce_bit", ce_bit, 0);
        chk("async_phase", os_phase, 0);
        chk("async_pending", cfg_pending, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_quiet", ce_os, 0);

        // limit 0 after reset: divide-by-1
        enable = 1'b1;
        @(negedge clock);
        chk("div1_a", ce_os, 1);
        @(negedge clock);
        chk("div1_b", ce_os, 1);
        chk("div1_phase", os_phase, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
